// File: rtl/bit32_serial_sub_pkg.sv
// Shared types and helpers for the digit-serial subtractor (bit32_serial_sub).
package bit32_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 32;
    localparam int DIGIT_DEF = 4;

    // Width of the digit counter; a single-digit configuration still needs one bit.
    function automatic int cnt_width(input int width, input int digit);
        int w;
        w = $clog2(width / digit);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bit32_serial_sub_digit_sub.sv
// Combinational DIGIT-bit ripple subtract cell: d = a - b - bi, with borrow out
// and the borrow into the top bit (used for signed overflow detection).
module digit_sub #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo,
    output logic             btop
);

    logic [DIGIT:0] chain;

    always_comb begin
        chain    = '0;
        d        = '0;
        chain[0] = bi;
        for (int i = 0; i < DIGIT; i++) begin
            d[i]         = a[i] ^ b[i] ^ chain[i];
            chain[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
        end
    end

    assign bo   = chain[DIGIT];
    assign btop = chain[DIGIT-1];

endmodule

// File: rtl/bit32_serial_sub.sv
// Digit-serial subtractor: out = in1 - in2 - bin over WIDTH/DIGIT cycles, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module bit32_serial_sub
    import bit32_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Handshake: start is accepted only in IDLE or DONE and latches the operands on
    // that edge; busy is high for exactly N cycles in RUN; done then pulses for one
    // cycle with out/borrow valid, and they hold until the next accepted start.

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(WIDTH, DIGIT);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state;
    state_t           state_next;
    logic             accept;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             run_borrow;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] out_q;
    logic             borrow_q;

    logic [DIGIT-1:0] slice_d;
    logic             slice_bo;
    int               offset;

`ifdef SERIAL_SUB_OVF_EN
    logic             top_borrow;
    logic             ovf_q;
`else
    logic             unused_top_borrow;
`endif

    digit_sub #(
        .DIGIT(DIGIT)
    ) u_digit_sub (
        .a   (a_q[DIGIT-1:0]),
        .b   (b_q[DIGIT-1:0]),
        .bi  (run_borrow),
        .d   (slice_d),
        .bo  (slice_bo),
`ifdef SERIAL_SUB_OVF_EN
        .btop(top_borrow)
`else
        .btop(unused_top_borrow)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == LAST) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // Back-to-back: a start here is taken while done still pulses.
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign offset = int'(cnt) * DIGIT;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q        <= '0;
            b_q        <= '0;
            run_borrow <= 1'b0;
            cnt        <= '0;
            out_q      <= '0;
            borrow_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else if (accept) begin
            a_q        <= in1;
            b_q        <= in2;
            run_borrow <= bin;
            cnt        <= '0;
            out_q      <= '0;
            borrow_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else if (step) begin
            // Operands shift down so the cell always sees the current slice at bit 0.
            a_q                     <= a_q >> DIGIT;
            b_q                     <= b_q >> DIGIT;
            out_q[offset +: DIGIT]  <= slice_d;
            run_borrow              <= slice_bo;
            if (last) begin
                cnt      <= '0;
                borrow_q <= slice_bo;
`ifdef SERIAL_SUB_OVF_EN
                ovf_q    <= top_borrow ^ slice_bo;
`endif
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign busy   = (state == RUN);
    assign done   = (state == DONE);
    assign out    = out_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_bit32_serial_sub.sv
// Directed testbench for bit32_serial_sub: DIGIT=4 and DIGIT=1 instances share operands.
module tb_bit32_serial_sub;

    logic        clk = 1'b0;
    logic        reset;
    logic        start4;
    logic        start1;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        bin;
    logic        busy4, done4, borrow4;
    logic        busy1, done1, borrow1;
    logic [31:0] out4, out1;
`ifdef SERIAL_SUB_OVF_EN
    logic        ovf4, ovf1;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit32_serial_sub #(.WIDTH(32), .DIGIT(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .in1(in1), .in2(in2), .bin(bin),
        .busy(busy4), .done(done4), .out(out4), .borrow(borrow4)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf4)
`endif
    );

    bit32_serial_sub #(.WIDTH(32), .DIGIT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .in1(in1), .in2(in2), .bin(bin),
        .busy(busy1), .done(done1), .out(out1), .borrow(borrow1)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf1)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation on the chosen instance and wait (bounded) for done.
    // lat counts edges after the accepting edge; busy_cnt counts RUN cycles seen.
    task automatic run_op(input int which, input logic [31:0] x, input logic [31:0] y,
                          input logic bi, output int lat, output int busy_cnt);
        in1 = x;
        in2 = y;
        bin = bi;
        if (which == 1) start1 = 1'b1;
        else start4 = 1'b1;
        tick();
        start1   = 1'b0;
        start4   = 1'b0;
        in1      = ~x;
        in2      = x ^ y;
        bin      = ~bi;
        lat      = 0;
        busy_cnt = 0;
        while (!((which == 1) ? done1 : done4) && lat < 200) begin
            if ((which == 1) ? busy1 : busy4) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start4 = 1'b0;
        start1 = 1'b0;
        in1    = '0;
        in2    = '0;
        bin    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (out4 !== 32'h0) begin failures++; $display("FAIL reset_out4 got %h exp %h", out4, 32'h0); end
        checks++; if (borrow4 !== 1'b0) begin failures++; $display("FAIL reset_borrow4 got %b exp 0", borrow4); end
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL reset_busy4 got %b exp 0", busy4); end
        checks++; if (done4 !== 1'b0) begin failures++; $display("FAIL reset_done4 got %b exp 0", done4); end
        checks++; if ({busy1, done1, borrow1} !== 3'b000 || out1 !== 32'h0) begin
            failures++; $display("FAIL reset_dut1 got busy=%b done=%b borrow=%b out=%h exp all zero", busy1, done1, borrow1, out1);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++; if (ovf4 !== 1'b0) begin failures++; $display("FAIL reset_ovf4 got %b exp 0", ovf4); end
`endif
    endtask

    task automatic test_basic();
        int lat, bc;
        run_op(4, 32'h0000_0005, 32'h0000_0003, 1'b0, lat, bc);
        checks++; if (lat !== 8) begin failures++; $display("FAIL basic_latency got %0d exp 8", lat); end
        checks++; if (bc !== 8) begin failures++; $display("FAIL basic_busy_cycles got %0d exp 8", bc); end
        checks++; if (busy4 !== 1'b0) begin failures++; $display("FAIL basic_busy_with_done got %b exp 0", busy4); end
        checks++; if (out4 !== 32'h0000_0002) begin failures++; $display("FAIL basic_out got %h exp %h", out4, 32'h2); end
        checks++; if (borrow4 !== 1'b0) begin failures++; $display("FAIL basic_borrow got %b exp 0", borrow4); end
        tick();
        checks++; if (done4 !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got %b exp 0", done4); end
        checks++; if (out4 !== 32'h0000_0002) begin failures++; $display("FAIL basic_out_hold got %h exp %h", out4, 32'h2); end
    endtask

    task automatic test_wrap();
        int lat, bc;
        run_op(4, 32'h0000_0000, 32'h0000_0001, 1'b0, lat, bc);
        checks++; if (out4 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_out got %h exp %h", out4, 32'hFFFF_FFFF); end
        checks++; if (borrow4 !== 1'b1) begin failures++; $display("FAIL wrap_borrow got %b exp 1", borrow4); end
`ifdef SERIAL_SUB_OVF_EN
        checks++; if (ovf4 !== 1'b0) begin failures++; $display("FAIL wrap_ovf got %b exp 0", ovf4); end
`endif
        tick();
    endtask

    task automatic test_signed_ovf();
        int lat, bc;
        run_op(4, 32'h8000_0000, 32'h0000_0001, 1'b0, lat, bc);
        checks++; if (out4 !== 32'h7FFF_FFFF) begin failures++; $display("FAIL ovf_case_out got %h exp %h", out4, 32'h7FFF_FFFF); end
        checks++; if (borrow4 !== 1'b0) begin failures++; $display("FAIL ovf_case_borrow got %b exp 0", borrow4); end
`ifdef SERIAL_SUB_OVF_EN
        checks++; if (ovf4 !== 1'b1) begin failures++; $display("FAIL ovf_case_ovf got %b exp 1", ovf4); end
`endif
        tick();
    endtask

    task automatic test_equal_bin();
        int lat, bc;
        run_op(4, 32'h0000_8000, 32'h0000_8000, 1'b1, lat, bc);
        checks++; if (out4 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL eqbin4_out got %h exp %h", out4, 32'hFFFF_FFFF); end
        checks++; if (borrow4 !== 1'b1) begin failures++; $display("FAIL eqbin4_borrow got %b exp 1", borrow4); end
        tick();
        run_op(1, 32'h0000_8000, 32'h0000_8000, 1'b1, lat, bc);
        checks++; if (lat !== 32) begin failures++; $display("FAIL eqbin1_latency got %0d exp 32", lat); end
        checks++; if (bc !== 32) begin failures++; $display("FAIL eqbin1_busy_cycles got %0d exp 32", bc); end
        checks++; if (out1 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL eqbin1_out got %h exp %h", out1, 32'hFFFF_FFFF); end
        checks++; if (borrow1 !== 1'b1) begin failures++; $display("FAIL eqbin1_borrow got %b exp 1", borrow1); end
        tick();
    endtask

    task automatic test_start_in_run();
        int lat;
        in1    = 32'h0000_0064;
        in2    = 32'h0000_0001;
        bin    = 1'b0;
        start4 = 1'b1;
        tick();
        in1 = 32'hDEAD_0000;
        in2 = 32'h0000_1234;
        bin = 1'b1;
        lat = 0;
        while (!done4 && lat < 200) begin
            tick();
            lat++;
        end
        start4 = 1'b0;
        checks++; if (lat !== 8) begin failures++; $display("FAIL startrun_latency got %0d exp 8", lat); end
        checks++; if (out4 !== 32'h0000_0063) begin failures++; $display("FAIL startrun_out got %h exp %h", out4, 32'h63); end
        checks++; if (borrow4 !== 1'b0) begin failures++; $display("FAIL startrun_borrow got %b exp 0", borrow4); end
        tick();
        checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            failures++; $display("FAIL startrun_idle got busy=%b done=%b exp busy=0 done=0", busy4, done4);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        run_op(4, 32'h0000_0005, 32'h0000_0003, 1'b0, lat, bc);
        checks++; if (out4 !== 32'h0000_0002) begin failures++; $display("FAIL b2b_first_out got %h exp %h", out4, 32'h2); end
        in1    = 32'h1234_5678;
        in2    = 32'h0FED_CBA9;
        bin    = 1'b0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        in1    = 32'h0;
        in2    = 32'hFFFF_FFFF;
        checks++; if (busy4 !== 1'b1 || done4 !== 1'b0) begin
            failures++; $display("FAIL b2b_restart got busy=%b done=%b exp busy=1 done=0", busy4, done4);
        end
        lat = 0;
        while (!done4 && lat < 200) begin
            tick();
            lat++;
        end
        checks++; if (lat !== 8) begin failures++; $display("FAIL b2b_latency got %0d exp 8", lat); end
        checks++; if (out4 !== 32'h0246_8ACF) begin failures++; $display("FAIL b2b_second_out got %h exp %h", out4, 32'h0246_8ACF); end
        checks++; if (borrow4 !== 1'b0) begin failures++; $display("FAIL b2b_second_borrow got %b exp 0", borrow4); end
        tick();
    endtask

    task automatic test_reset_in_run();
        int lat, bc, seen;
        in1    = 32'hFFFF_FFFF;
        in2    = 32'h1111_1111;
        bin    = 1'b0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            failures++; $display("FAIL abort_flags got busy=%b done=%b exp busy=0 done=0", busy4, done4);
        end
        checks++; if (out4 !== 32'h0) begin failures++; $display("FAIL abort_out got %h exp %h", out4, 32'h0); end
        checks++; if (borrow4 !== 1'b0) begin failures++; $display("FAIL abort_borrow got %b exp 0", borrow4); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (done4 || busy4) seen++;
            tick();
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done got %0d active cycles exp 0", seen); end
        run_op(4, 32'h0000_0010, 32'h0000_0001, 1'b0, lat, bc);
        checks++; if (lat !== 8) begin failures++; $display("FAIL abort_rerun_latency got %0d exp 8", lat); end
        checks++; if (out4 !== 32'h0000_000F) begin failures++; $display("FAIL abort_rerun_out got %h exp %h", out4, 32'hF); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_signed_ovf();
        test_equal_bin();
        test_start_in_run();
        test_back_to_back();
        test_reset_in_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
